// File: rtl/tx_frame_sched_cond.sv
// -----------------------------------------------------------------------------
// tx_frame_sched_cond
// Transmit-side framing scheduler. It drives the 4-bit symbol select of the TX
// input multiplexer. The block does the following:
//   - arbitrates between pending TLP and DLLP requests (round-robin when both
//     are pending),
//   - frames each packet as STP/SDP, payload, then END (or EDB on abort),
//   - inserts a COM+SKP ordered set at packet boundaries when one is due,
//   - selects IDL otherwise.
//
// Optional feature macro: TX_SCHED_SKP_EN
//   When defined, the periodic COM/SKP ordered-set scheduling is built in.
//   When undefined, the skip counter and the COM/SKP states are absent.
//
// Ports:
//   CLK        in   1      clock, rising edge
//   reset      in   1      synchronous, active-high
//   ENB        in   1      enable; low freezes all state and outputs
//   tlp_req    in   1      TLP pending, held until tlp_ack
//   tlp_len    in   LEN_W  TLP payload length (0 treated as 1), sampled at grant
//   dllp_req   in   1      DLLP pending, held until dllp_ack
//   tlp_abort  in   1      nullify the TLP currently in its payload
//   CTRL       out  4      mux select (0 data,1 COM,2 PAD,3 SKP,4 STP,5 SDP,
//                          6 END,7 EDB,8 FTS,9 IDL)
//   tlp_ack    out  1      pulse in the STP cycle
//   dllp_ack   out  1      pulse in the SDP cycle
//   data_rd    out  1      high on each payload (CTRL=0) cycle
//   busy       out  1      high whenever not idle
// -----------------------------------------------------------------------------
module tx_frame_sched_cond #(
  parameter int LEN_W        = 4,
  parameter int DLLP_LEN     = 6,
  parameter int N_SKP        = 3,
  parameter int SKP_INTERVAL = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             ENB,
  input  logic             tlp_req,
  input  logic [LEN_W-1:0] tlp_len,
  input  logic             dllp_req,
  input  logic             tlp_abort,
  output logic [3:0]       CTRL,
  output logic             tlp_ack,
  output logic             dllp_ack,
  output logic             data_rd,
  output logic             busy
);

  localparam int DLLP_W = $clog2(DLLP_LEN + 1);
  localparam int CNT_W  = (LEN_W > DLLP_W) ? LEN_W : DLLP_W;

  localparam logic [3:0] SEL_DATA = 4'd0;
  localparam logic [3:0] SEL_COM  = 4'd1;
  localparam logic [3:0] SEL_SKP  = 4'd3;
  localparam logic [3:0] SEL_STP  = 4'd4;
  localparam logic [3:0] SEL_SDP  = 4'd5;
  localparam logic [3:0] SEL_END  = 4'd6;
  localparam logic [3:0] SEL_EDB  = 4'd7;
  localparam logic [3:0] SEL_IDL  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_END   = 3'd3,
`ifdef TX_SCHED_SKP_EN
    ST_COM   = 3'd5,
    ST_SKP   = 3'd6,
`endif
    ST_ABORT = 3'd4
  } state_t;

  state_t           state_r, state_nxt;
  logic             is_tlp_r, is_tlp_nxt;
  logic [CNT_W-1:0] len_cnt_r, len_cnt_nxt;
  logic             rr_r, rr_nxt;
  logic             decide_s;
  logic             skp_pend_s;
  logic [3:0]       ctrl_nxt;
  logic             tlp_ack_nxt, dllp_ack_nxt, data_rd_nxt, busy_nxt;

`ifdef TX_SCHED_SKP_EN
  localparam int SKP_W = $clog2(SKP_INTERVAL);
  localparam int IDX_W = $clog2(N_SKP + 1);

  logic [SKP_W-1:0] skp_cnt_r;
  logic             skp_pend_r;
  logic [IDX_W-1:0] skp_idx_r, skp_idx_nxt;
  logic             skp_expire_s;

  assign skp_expire_s = (skp_cnt_r == SKP_W'(SKP_INTERVAL - 1));
  assign skp_pend_s   = skp_pend_r;

  // Skip interval counter and single-entry pending flag; a new expiry beats
  // the clear that happens while COM is on the wire.
  always_ff @(posedge CLK) begin
    if (reset) begin
      skp_cnt_r  <= {SKP_W{1'b0}};
      skp_pend_r <= 1'b0;
      skp_idx_r  <= {IDX_W{1'b0}};
    end else if (ENB) begin
      skp_cnt_r <= skp_expire_s ? {SKP_W{1'b0}} : skp_cnt_r + SKP_W'(1);
      if (skp_expire_s) begin
        skp_pend_r <= 1'b1;
      end else if (state_r == ST_COM) begin
        skp_pend_r <= 1'b0;
      end
      skp_idx_r <= skp_idx_nxt;
    end
  end
`else
  assign skp_pend_s = 1'b0;
`endif

  // Next-state logic: packet sequencing plus the shared decision point.
  always_comb begin
    state_nxt   = state_r;
    is_tlp_nxt  = is_tlp_r;
    len_cnt_nxt = len_cnt_r;
    rr_nxt      = rr_r;
    decide_s    = 1'b0;
`ifdef TX_SCHED_SKP_EN
    skp_idx_nxt = skp_idx_r;
`endif
    case (state_r)
      ST_IDLE, ST_END, ST_ABORT: decide_s = 1'b1;
      ST_START: state_nxt = ST_DATA;
      ST_DATA: begin
        // Abort only applies to TLPs; it overrides the normal END.
        if (is_tlp_r && tlp_abort) begin
          state_nxt = ST_ABORT;
        end else if (len_cnt_r == CNT_W'(1)) begin
          state_nxt = ST_END;
        end else begin
          len_cnt_nxt = len_cnt_r - CNT_W'(1);
        end
      end
`ifdef TX_SCHED_SKP_EN
      ST_COM: begin
        state_nxt   = ST_SKP;
        skp_idx_nxt = {IDX_W{1'b0}};
      end
      ST_SKP: begin
        if (skp_idx_r == IDX_W'(N_SKP - 1)) begin
          decide_s = 1'b1;
        end else begin
          skp_idx_nxt = skp_idx_r + IDX_W'(1);
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase

    if (decide_s) begin
      if (skp_pend_s) begin
`ifdef TX_SCHED_SKP_EN
        state_nxt = ST_COM;
`else
        state_nxt = ST_IDLE;
`endif
      end else if (tlp_req && (!dllp_req || !rr_r)) begin
        state_nxt   = ST_START;
        is_tlp_nxt  = 1'b1;
        len_cnt_nxt = (tlp_len == {LEN_W{1'b0}}) ? CNT_W'(1) : CNT_W'(tlp_len);
        rr_nxt      = ~rr_r;
      end else if (dllp_req) begin
        state_nxt   = ST_START;
        is_tlp_nxt  = 1'b0;
        len_cnt_nxt = CNT_W'(DLLP_LEN);
        rr_nxt      = ~rr_r;
      end else begin
        state_nxt = ST_IDLE;
      end
    end else begin
      rr_nxt = rr_r;
    end
  end

  // Output decode from the upcoming state so outputs can be registered
  // without adding a cycle of latency.
  always_comb begin
    ctrl_nxt     = SEL_IDL;
    tlp_ack_nxt  = 1'b0;
    dllp_ack_nxt = 1'b0;
    data_rd_nxt  = 1'b0;
    busy_nxt     = 1'b1;
    case (state_nxt)
      ST_IDLE: busy_nxt = 1'b0;
      ST_START: begin
        if (is_tlp_nxt) begin
          ctrl_nxt    = SEL_STP;
          tlp_ack_nxt = 1'b1;
        end else begin
          ctrl_nxt     = SEL_SDP;
          dllp_ack_nxt = 1'b1;
        end
      end
      ST_DATA: begin
        ctrl_nxt    = SEL_DATA;
        data_rd_nxt = 1'b1;
      end
      ST_END:   ctrl_nxt = SEL_END;
      ST_ABORT: ctrl_nxt = SEL_EDB;
`ifdef TX_SCHED_SKP_EN
      ST_COM:   ctrl_nxt = SEL_COM;
      ST_SKP:   ctrl_nxt = SEL_SKP;
`endif
      default: busy_nxt = 1'b0;
    endcase
  end

  // State and registered outputs; ENB low holds everything.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      is_tlp_r  <= 1'b0;
      len_cnt_r <= {CNT_W{1'b0}};
      rr_r      <= 1'b0;
      CTRL      <= SEL_IDL;
      tlp_ack   <= 1'b0;
      dllp_ack  <= 1'b0;
      data_rd   <= 1'b0;
      busy      <= 1'b0;
    end else if (ENB) begin
      state_r   <= state_nxt;
      is_tlp_r  <= is_tlp_nxt;
      len_cnt_r <= len_cnt_nxt;
      rr_r      <= rr_nxt;
      CTRL      <= ctrl_nxt;
      tlp_ack   <= tlp_ack_nxt;
      dllp_ack  <= dllp_ack_nxt;
      data_rd   <= data_rd_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_tx_frame_sched_cond.sv
// -----------------------------------------------------------------------------
// tb_tx_frame_sched_cond
// Scoreboard bench for tx_frame_sched_cond. A symbol-plan reference model
// enqueues the expected output vector every clock; a separate monitor pops
// and compares on the opposite clock edge.
// -----------------------------------------------------------------------------
module tb_tx_frame_sched_cond;

  localparam int LEN_W        = 4;
  localparam int DLLP_LEN     = 6;
  localparam int N_SKP        = 3;
  localparam int SKP_INTERVAL = 16;
`ifdef TX_SCHED_SKP_EN
  localparam bit SKP_EN = 1'b1;
`else
  localparam bit SKP_EN = 1'b0;
`endif

  localparam logic [3:0] C_DATA = 4'd0, C_COM = 4'd1, C_SKP = 4'd3, C_STP = 4'd4,
                         C_SDP = 4'd5, C_END = 4'd6, C_EDB = 4'd7, C_IDL = 4'd9;

  logic             CLK = 1'b0;
  logic             reset, ENB, tlp_req, dllp_req, tlp_abort;
  logic [LEN_W-1:0] tlp_len;
  logic [3:0]       CTRL;
  logic             tlp_ack, dllp_ack, data_rd, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  tx_frame_sched_cond #(
    .LEN_W(LEN_W), .DLLP_LEN(DLLP_LEN), .N_SKP(N_SKP), .SKP_INTERVAL(SKP_INTERVAL)
  ) dut (
    .CLK(CLK), .reset(reset), .ENB(ENB), .tlp_req(tlp_req), .tlp_len(tlp_len),
    .dllp_req(dllp_req), .tlp_abort(tlp_abort), .CTRL(CTRL), .tlp_ack(tlp_ack),
    .dllp_ack(dllp_ack), .data_rd(data_rd), .busy(busy)
  );

  // Expected output vector {ctrl, tlp_ack, dllp_ack, data_rd, busy}.
  function automatic logic [7:0] sym(input logic [3:0] c, input logic ta, input logic da);
    return {c, ta, da, (c == C_DATA), (c != C_IDL)};
  endfunction

  logic [7:0] exp_q[$];

  // Reference model: a plan queue holds the symbols still to be sent for the
  // current packet/ordered set; an empty plan means a decision is due.
  logic [7:0] m_cur;
  logic [7:0] m_plan[$];
  int         m_cnt;
  bit         m_pend, m_rr, m_in_tlp;

  always @(posedge CLK) begin : model
    bit expire;
    int n;
    if (reset) begin
      m_cur    = sym(C_IDL, 1'b0, 1'b0);
      m_plan.delete();
      m_cnt    = 0;
      m_pend   = 1'b0;
      m_rr     = 1'b0;
      m_in_tlp = 1'b0;
    end else if (ENB) begin
      expire = 1'b0;
      if (SKP_EN) begin
        expire = (m_cnt == SKP_INTERVAL - 1);
        m_cnt  = (m_cnt + 1) % SKP_INTERVAL;
      end
      if (m_cur[7:4] == C_DATA && m_in_tlp && tlp_abort) begin
        m_plan.delete();
        m_plan.push_back(sym(C_EDB, 1'b0, 1'b0));
      end
      if (m_plan.size() == 0) begin
        if (SKP_EN && m_pend) begin
          m_plan.push_back(sym(C_COM, 1'b0, 1'b0));
          repeat (N_SKP) m_plan.push_back(sym(C_SKP, 1'b0, 1'b0));
        end else if (tlp_req && (!dllp_req || !m_rr)) begin
          n = (tlp_len == 0) ? 1 : int'(tlp_len);
          m_plan.push_back(sym(C_STP, 1'b1, 1'b0));
          repeat (n) m_plan.push_back(sym(C_DATA, 1'b0, 1'b0));
          m_plan.push_back(sym(C_END, 1'b0, 1'b0));
          m_in_tlp = 1'b1;
          m_rr     = !m_rr;
        end else if (dllp_req) begin
          m_plan.push_back(sym(C_SDP, 1'b0, 1'b1));
          repeat (DLLP_LEN) m_plan.push_back(sym(C_DATA, 1'b0, 1'b0));
          m_plan.push_back(sym(C_END, 1'b0, 1'b0));
          m_in_tlp = 1'b0;
          m_rr     = !m_rr;
        end else begin
          m_plan.push_back(sym(C_IDL, 1'b0, 1'b0));
        end
      end
      if (m_cur[7:4] == C_COM) m_pend = 1'b0;
      if (expire) m_pend = 1'b1;
      m_cur = m_plan.pop_front();
    end
    exp_q.push_back(m_cur);
  end

  // Monitor: compare the DUT output against the oldest expected vector.
  always @(negedge CLK) begin : monitor
    logic [7:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {CTRL, tlp_ack, dllp_ack, data_rd, busy};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL sched_out t=%0t: actual ctrl=%0d tack=%b dack=%b rd=%b busy=%b, required ctrl=%0d tack=%b dack=%b rd=%b busy=%b",
                 $time, a[7:4], a[3], a[2], a[1], a[0], e[7:4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic check_cond(input bit ok, input string what);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s t=%0t: actual ctrl=%0d tack=%b dack=%b rd=%b busy=%b",
               what, $time, CTRL, tlp_ack, dllp_ack, data_rd, busy);
    end
  endtask

  // One stimulus cycle; requesters withdraw once their ack is seen.
  task automatic cyc();
    @(negedge CLK);
    if (tlp_ack) tlp_req = 1'b0;
    if (dllp_ack) dllp_req = 1'b0;
  endtask

  initial begin
    int dcnt;
    bit done;
    bit got_ack;
    reset = 1'b1; ENB = 1'b1; tlp_req = 1'b0; dllp_req = 1'b0;
    tlp_abort = 1'b0; tlp_len = '0;
    repeat (3) cyc();
    check_cond((CTRL === C_IDL) && (tlp_ack === 1'b0) && (dllp_ack === 1'b0) &&
               (data_rd === 1'b0) && (busy === 1'b0), "reset_state");
    reset = 1'b0;
    repeat (40) cyc();                       // idle, periodic ordered sets

    tlp_req = 1'b1; tlp_len = LEN_W'(3);     // single TLP
    got_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (tlp_ack) got_ack = 1'b1;
    end
    check_cond(got_ack, "tlp_ack_wait_expired");

    reset = 1'b1; cyc(); reset = 1'b0;       // arbitration from rr=0
    tlp_req = 1'b1; tlp_len = LEN_W'(2); dllp_req = 1'b1;
    repeat (25) cyc();

    tlp_req = 1'b1; tlp_len = LEN_W'(5);     // abort on 2nd payload cycle
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      tlp_abort = 1'b0;
      if (data_rd) begin
        dcnt++;
        if (dcnt == 2) tlp_abort = 1'b1;
      end
    end
    tlp_abort = 1'b0;

    tlp_req = 1'b1; tlp_len = LEN_W'(8);     // reset mid-payload
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      reset = 1'b0;
      if (data_rd && !done) begin
        reset = 1'b1;
        done  = 1'b1;
      end
    end
    reset = 1'b0;

    tlp_req = 1'b1; tlp_len = LEN_W'(8);     // long TLP across an expiry
    repeat (30) cyc();

    for (int i = 0; i < 4000; i++) begin
      cyc();
      ENB       = ($urandom_range(0, 9) != 0);
      reset     = ($urandom_range(0, 299) == 0);
      tlp_abort = ($urandom_range(0, 24) == 0);
      if (!tlp_req && !tlp_ack && $urandom_range(0, 3) == 0) begin
        tlp_req = 1'b1;
        tlp_len = LEN_W'($urandom_range(0, 15));
      end
      if (!dllp_req && !dllp_ack && $urandom_range(0, 3) == 0) dllp_req = 1'b1;
    end

    ENB = 1'b1; reset = 1'b0; tlp_abort = 1'b0;
    repeat (40) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
